// File: rtl/vga_timing_gen.sv
// VGA sync/timing generator: pixel clock-enable divider, h/v counters and registered sync/DE/coordinate outputs.
// Optional RGB332 colour-bar output enabled by defining VGA_TEST_PATTERN_EN.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          pix_ce,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TEST_PATTERN_EN
  ,
  output logic [7:0]    rgb
`endif
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST = CW'(H_TOT - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOT - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] d_q, d_d;
  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic          d_wrap, h_wrap, v_wrap;

  logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          ce_q, ce_d, ls_q, ls_d, fs_q, fs_d;

  // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    d_wrap = (d_q == D_LAST);
    h_wrap = (h_q == H_LAST);
    v_wrap = (v_q == V_LAST);
    d_d    = d_q;
    h_d    = h_q;
    v_d    = v_q;
    if (en) begin
      d_d = d_wrap ? '0 : d_q + 1'b1;
      if (d_wrap) begin
        h_d = h_wrap ? '0 : h_q + 1'b1;
        if (h_wrap) v_d = v_wrap ? '0 : v_q + 1'b1;
      end
    end
  end

  // Output values derived from the pre-update counters; registered below for one clk of latency.
  always_comb begin
    de_d = (h_q < H_ACT) && (v_q < V_ACT);
    x_d  = de_d ? h_q : '0;
    y_d  = de_d ? v_q : '0;
    hs_d = ((h_q >= HS_BEG) && (h_q < HS_END)) ? HS_POL : ~HS_POL;
    vs_d = ((v_q >= VS_BEG) && (v_q < VS_END)) ? VS_POL : ~VS_POL;
    ce_d = en && d_wrap;
    ls_d = ce_d && (h_q == '0);
    fs_d = ls_d && (v_q == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q  <= '0;
      h_q  <= '0;
      v_q  <= '0;
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
      de_q <= 1'b0;
      x_q  <= '0;
      y_q  <= '0;
      ce_q <= 1'b0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      d_q  <= d_d;
      h_q  <= h_d;
      v_q  <= v_d;
      ce_q <= ce_d;
      ls_q <= ls_d;
      fs_q <= fs_d;
      // Pixel-level outputs freeze with the counters so a paused frame resumes seamlessly.
      if (en) begin
        hs_q <= hs_d;
        vs_q <= vs_d;
        de_q <= de_d;
        x_q  <= x_d;
        y_q  <= y_d;
      end
    end
  end

  assign pix_ce      = ce_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0] bar;
  logic [7:0] rgb_q, rgb_d;

  // Bar index by threshold compare, avoiding a divider for non-power-of-two bar widths.
  always_comb begin
    bar = '0;
    for (int k = 1; k < 8; k++) begin
      if (h_q >= CW'(k * BAR_W)) bar = 3'(k);
    end
    rgb_d = 8'h00;
    if (de_d) begin
      case (bar)
        3'd0:    rgb_d = 8'hFF;
        3'd1:    rgb_d = 8'hFC;
        3'd2:    rgb_d = 8'h1F;
        3'd3:    rgb_d = 8'h1C;
        3'd4:    rgb_d = 8'hE3;
        3'd5:    rgb_d = 8'hE0;
        3'd6:    rgb_d = 8'h03;
        default: rgb_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)     rgb_q <= 8'h00;
    else if (en) rgb_q <= rgb_d;
  end

  assign rgb = rgb_q;
`endif

endmodule
